// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed address/data bus master:
// state encoding, default phase length and strobe levels.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_A_SETUP  = 3'd1,
        ST_A_STROBE = 3'd2,
        ST_A_HOLD   = 3'd3,
        ST_D_SETUP  = 3'd4,
        ST_D_STROBE = 3'd5,
        ST_D_HOLD   = 3'd6
    } bus_state_t;

    localparam int   T_PHASE_DEFAULT = 4;
    localparam logic STROBE_IDLE     = 1'b1;
    localparam logic STROBE_ACTIVE   = 1'b0;

    // Fixed phase order of a transfer; the hold phase of data returns to idle.
    function automatic bus_state_t next_phase(input bus_state_t s);
        case (s)
            ST_A_SETUP:  next_phase = ST_A_STROBE;
            ST_A_STROBE: next_phase = ST_A_HOLD;
            ST_A_HOLD:   next_phase = ST_D_SETUP;
            ST_D_SETUP:  next_phase = ST_D_STROBE;
            ST_D_STROBE: next_phase = ST_D_HOLD;
            ST_D_HOLD:   next_phase = ST_IDLE;
            default:     next_phase = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase length counter: counts 0..T_PHASE-1 while run is high and flags the
// last cycle of the phase; restarts at zero whenever the phase ends or run drops.
module phase_timer #(
    parameter int T_PHASE = 4
) (
    input  logic clk,
    input  logic Reset,
    input  logic run,
    output logic tc
);

    localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CW-1:0] LAST = CW'(T_PHASE - 1);

    logic [CW-1:0] cnt_r;

    // Phase cycle counter, cleared at each phase boundary so it never wraps.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r <= '0;
        end else if (!run || tc) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tc = run && (cnt_r == LAST);

endmodule

// File: rtl/rtc_ad_bus.sv
// RTC bus master: runs one address phase and one data phase on a multiplexed
// AD bus for each accepted request; all bus outputs are registered.
module rtc_ad_bus
    import rtc_bus_pkg::*;
#(
    parameter int T_PHASE = T_PHASE_DEFAULT
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       req,
    input  logic       wr,
    input  logic [7:0] address,
    input  logic [7:0] data_mod,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_rd,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       AD_n
);

    bus_state_t state_r, state_nxt_s;
    logic       phase_tc_s;
    logic       accept_s;
    logic       wr_r;
    logic [7:0] addr_r, wdata_r;
    logic       wr_nxt_s;
    logic [7:0] addr_nxt_s, wdata_nxt_s;

    logic       busy_r, done_r, ad_oe_r, cs_n_r, rd_n_r, wr_n_r, ad_n_r;
    logic [7:0] ad_out_r, data_rd_r;
    logic       busy_nxt_s, done_nxt_s, ad_oe_nxt_s;
    logic       cs_n_nxt_s, rd_n_nxt_s, wr_n_nxt_s, ad_n_nxt_s;
    logic [7:0] ad_out_nxt_s;

    phase_timer #(.T_PHASE(T_PHASE)) u_phase_timer (
        .clk   (clk),
        .Reset (Reset),
        .run   (state_r != ST_IDLE),
        .tc    (phase_tc_s)
    );

    assign accept_s    = (state_r == ST_IDLE) && req;
    assign wr_nxt_s    = accept_s ? wr       : wr_r;
    assign addr_nxt_s  = accept_s ? address  : addr_r;
    assign wdata_nxt_s = accept_s ? data_mod : wdata_r;

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        if (state_r == ST_IDLE) begin
            if (req) begin
                state_nxt_s = ST_A_SETUP;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (phase_tc_s) begin
            state_nxt_s = next_phase(state_r);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Bus output values for the state about to be entered, so the registered
    // outputs line up with the state register.
    always_comb begin
        cs_n_nxt_s   = STROBE_IDLE;
        rd_n_nxt_s   = STROBE_IDLE;
        wr_n_nxt_s   = STROBE_IDLE;
        ad_n_nxt_s   = 1'b1;
        ad_oe_nxt_s  = 1'b0;
        ad_out_nxt_s = 8'h00;
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        done_nxt_s   = (state_r == ST_D_HOLD) && phase_tc_s;
        case (state_nxt_s)
            ST_A_SETUP, ST_A_HOLD: begin
                ad_n_nxt_s   = 1'b0;
                ad_oe_nxt_s  = 1'b1;
                ad_out_nxt_s = addr_nxt_s;
            end
            ST_A_STROBE: begin
                ad_n_nxt_s   = 1'b0;
                ad_oe_nxt_s  = 1'b1;
                ad_out_nxt_s = addr_nxt_s;
                cs_n_nxt_s   = STROBE_ACTIVE;
                wr_n_nxt_s   = STROBE_ACTIVE;
            end
            ST_D_SETUP, ST_D_HOLD: begin
                ad_oe_nxt_s  = wr_nxt_s;
                ad_out_nxt_s = wr_nxt_s ? wdata_nxt_s : 8'h00;
            end
            ST_D_STROBE: begin
                ad_oe_nxt_s  = wr_nxt_s;
                ad_out_nxt_s = wr_nxt_s ? wdata_nxt_s : 8'h00;
                cs_n_nxt_s   = STROBE_ACTIVE;
                if (wr_nxt_s) begin
                    wr_n_nxt_s = STROBE_ACTIVE;
                end else begin
                    rd_n_nxt_s = STROBE_ACTIVE;
                end
            end
            default: begin
                ad_oe_nxt_s = 1'b0;
            end
        endcase
    end

    // State register and request latches.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            wr_r    <= 1'b0;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            wr_r    <= wr_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
        end
    end

    // Registered bus outputs; read data is taken on the final strobe cycle.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ad_oe_r   <= 1'b0;
            ad_out_r  <= 8'h00;
            cs_n_r    <= STROBE_IDLE;
            rd_n_r    <= STROBE_IDLE;
            wr_n_r    <= STROBE_IDLE;
            ad_n_r    <= 1'b1;
            data_rd_r <= 8'h00;
        end else begin
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            ad_oe_r  <= ad_oe_nxt_s;
            ad_out_r <= ad_out_nxt_s;
            cs_n_r   <= cs_n_nxt_s;
            rd_n_r   <= rd_n_nxt_s;
            wr_n_r   <= wr_n_nxt_s;
            ad_n_r   <= ad_n_nxt_s;
            if ((state_r == ST_D_STROBE) && phase_tc_s && !wr_r) begin
                data_rd_r <= ad_in;
            end else begin
                data_rd_r <= data_rd_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign ad_oe   = ad_oe_r;
    assign ad_out  = ad_out_r;
    assign CS_n    = cs_n_r;
    assign RD_n    = rd_n_r;
    assign WR_n    = wr_n_r;
    assign AD_n    = ad_n_r;
    assign data_rd = data_rd_r;

endmodule

// File: tb/tb_rtc_ad_bus.sv
// Directed bench for rtc_ad_bus at T_PHASE = 4, 2 and 255, with a strobe
// exclusion check on every clock.
module tb_rtc_ad_bus;

    logic       clk;
    logic       Reset;
    logic       wr;
    logic [7:0] address, data_mod, ad_in;
    logic [2:0] req_v;
    logic [2:0] busy_v, done_v, ad_oe_v, cs_n_v, rd_n_v, wr_n_v, ad_n_v;
    logic [7:0] ad_out_v [3];
    logic [7:0] data_rd_v [3];

    int checks = 0;
    int fails  = 0;
    int r_addr_cyc, r_addr_strb, r_data_cyc, r_data_strb, r_oe_data, r_done_at, r_done_cnt;
    logic [7:0] r_dr_done;
    int d1, d2, nd;

    rtc_ad_bus #(.T_PHASE(4)) dut4 (
        .clk(clk), .Reset(Reset), .req(req_v[0]), .wr(wr), .address(address),
        .data_mod(data_mod), .busy(busy_v[0]), .done(done_v[0]), .data_rd(data_rd_v[0]),
        .ad_out(ad_out_v[0]), .ad_oe(ad_oe_v[0]), .ad_in(ad_in), .CS_n(cs_n_v[0]),
        .RD_n(rd_n_v[0]), .WR_n(wr_n_v[0]), .AD_n(ad_n_v[0]));

    rtc_ad_bus #(.T_PHASE(2)) dut2 (
        .clk(clk), .Reset(Reset), .req(req_v[1]), .wr(wr), .address(address),
        .data_mod(data_mod), .busy(busy_v[1]), .done(done_v[1]), .data_rd(data_rd_v[1]),
        .ad_out(ad_out_v[1]), .ad_oe(ad_oe_v[1]), .ad_in(ad_in), .CS_n(cs_n_v[1]),
        .RD_n(rd_n_v[1]), .WR_n(wr_n_v[1]), .AD_n(ad_n_v[1]));

    rtc_ad_bus #(.T_PHASE(255)) dut255 (
        .clk(clk), .Reset(Reset), .req(req_v[2]), .wr(wr), .address(address),
        .data_mod(data_mod), .busy(busy_v[2]), .done(done_v[2]), .data_rd(data_rd_v[2]),
        .ad_out(ad_out_v[2]), .ad_oe(ad_oe_v[2]), .ad_in(ad_in), .CS_n(cs_n_v[2]),
        .RD_n(rd_n_v[2]), .WR_n(wr_n_v[2]), .AD_n(ad_n_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check strobe exclusion on every instance.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            assert (!((rd_n_v[k] === 1'b0 && wr_n_v[k] === 1'b0) ||
                      (ad_oe_v[k] === 1'b1 && rd_n_v[k] === 1'b0))) else begin
                fails++;
                $error("FAIL strobe_excl dut%0d observed rd_n=%b wr_n=%b ad_oe=%b expected no overlap",
                       k, rd_n_v[k], wr_n_v[k], ad_oe_v[k]);
            end
        end
    endtask

    // One transfer on instance sel, measuring phase lengths and done timing.
    // The RTC model drives 0x59 while RD_n is low and 0xA5 otherwise.
    task automatic xfer(input int sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int maxc);
        r_addr_cyc = 0; r_addr_strb = 0; r_data_cyc = 0; r_data_strb = 0;
        r_oe_data = 0; r_done_at = 0; r_done_cnt = 0; r_dr_done = 8'h00;
        wr = w; address = a; data_mod = d; ad_in = 8'hA5;
        req_v[sel] = 1'b1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (i == 1) req_v[sel] = 1'b0;
            if (!ad_n_v[sel] && ad_oe_v[sel] && ad_out_v[sel] == a) r_addr_cyc++;
            if (!ad_n_v[sel] && !cs_n_v[sel] && !wr_n_v[sel] && rd_n_v[sel]) r_addr_strb++;
            if (ad_n_v[sel] && busy_v[sel]) begin
                r_data_cyc++;
                if (ad_oe_v[sel]) r_oe_data++;
                if (w && !cs_n_v[sel] && !wr_n_v[sel] && rd_n_v[sel] && ad_oe_v[sel] && ad_out_v[sel] == d)
                    r_data_strb++;
                if (!w && !cs_n_v[sel] && !rd_n_v[sel] && wr_n_v[sel]) r_data_strb++;
            end
            if (done_v[sel]) begin
                r_done_cnt++;
                if (r_done_at == 0) begin
                    r_done_at = i;
                    r_dr_done = data_rd_v[sel];
                end
            end
            ad_in = (rd_n_v[sel] == 1'b0) ? 8'h59 : 8'hA5;
        end
    endtask

    initial begin
        Reset = 1'b0; req_v = 3'b000; wr = 1'b0;
        address = 8'h00; data_mod = 8'h00; ad_in = 8'h00;
        tick(); tick();
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_done", done_v[0], 1'b0);
        check("rst_data_rd", data_rd_v[0], 8'h00);
        check("rst_ad_out", ad_out_v[0], 8'h00);
        check("rst_ad_oe", ad_oe_v[0], 1'b0);
        check("rst_strobes", {cs_n_v[0], rd_n_v[0], wr_n_v[0], ad_n_v[0]}, 4'b1111);
        Reset = 1'b1;
        tick();

        // Write 0x45 to address 0x21.
        xfer(0, 1'b1, 8'h21, 8'h45, 40);
        check("wr_addr_cycles", r_addr_cyc, 12);
        check("wr_addr_strobe", r_addr_strb, 4);
        check("wr_data_cycles", r_data_cyc, 12);
        check("wr_data_oe", r_oe_data, 12);
        check("wr_data_strobe", r_data_strb, 4);
        check("wr_done_at", r_done_at, 25);
        check("wr_done_count", r_done_cnt, 1);
        check("wr_data_rd_kept", data_rd_v[0], 8'h00);

        // Read of address 0x22; RTC answers 0x59 during the read strobe.
        xfer(0, 1'b0, 8'h22, 8'h00, 40);
        check("rd_addr_cycles", r_addr_cyc, 12);
        check("rd_addr_strobe", r_addr_strb, 4);
        check("rd_data_oe", r_oe_data, 0);
        check("rd_rd_strobe", r_data_strb, 4);
        check("rd_done_at", r_done_at, 25);
        check("rd_data_at_done", r_dr_done, 8'h59);

        // A following write leaves data_rd alone.
        xfer(0, 1'b1, 8'h30, 8'h77, 40);
        check("wr2_done_at", r_done_at, 25);
        check("wr2_data_rd_kept", data_rd_v[0], 8'h59);

        // Back-to-back: req held through two transfers, then pulsed while busy.
        wr = 1'b1; address = 8'h40; data_mod = 8'h11;
        d1 = 0; d2 = 0; nd = 0;
        req_v[0] = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 26) req_v[0] = 1'b0;
            if (i == 30) req_v[0] = 1'b1;
            if (i == 32) req_v[0] = 1'b0;
            if (done_v[0]) begin
                nd++;
                if (nd == 1) d1 = i;
                if (nd == 2) d2 = i;
            end
        end
        check("b2b_first_done", d1, 25);
        check("b2b_spacing", d2 - d1, 25);
        check("b2b_done_count", nd, 2);
        check("b2b_idle_after", busy_v[0], 1'b0);

        // Reset asserted during D_STROBE of a read.
        wr = 1'b0; address = 8'h22; ad_in = 8'hA5;
        req_v[0] = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 1) req_v[0] = 1'b0;
            ad_in = (rd_n_v[0] == 1'b0) ? 8'h59 : 8'hA5;
        end
        check("abort_in_dstrobe", rd_n_v[0], 1'b0);
        Reset = 1'b0;
        #1;
        check("abort_strobes", {cs_n_v[0], rd_n_v[0], wr_n_v[0], ad_n_v[0]}, 4'b1111);
        check("abort_ad_oe", ad_oe_v[0], 1'b0);
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_data_rd", data_rd_v[0], 8'h00);
        nd = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (done_v[0]) nd++;
        end
        Reset = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done_v[0]) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_idle_busy", busy_v[0], 1'b0);

        // Shortest phase.
        xfer(1, 1'b1, 8'h0F, 8'hC3, 20);
        check("t2_addr_cycles", r_addr_cyc, 6);
        check("t2_addr_strobe", r_addr_strb, 2);
        check("t2_data_cycles", r_data_cyc, 6);
        check("t2_data_strobe", r_data_strb, 2);
        check("t2_done_at", r_done_at, 13);
        check("t2_done_count", r_done_cnt, 1);

        // Longest phase.
        xfer(2, 1'b0, 8'h5A, 8'h00, 1545);
        check("t255_addr_cycles", r_addr_cyc, 765);
        check("t255_addr_strobe", r_addr_strb, 255);
        check("t255_data_cycles", r_data_cyc, 765);
        check("t255_rd_strobe", r_data_strb, 255);
        check("t255_data_oe", r_oe_data, 0);
        check("t255_done_at", r_done_at, 1531);
        check("t255_done_count", r_done_cnt, 1);
        check("t255_data_rd", r_dr_done, 8'h59);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rtc_ad_bus.md
RTC_AD_BUS -- requirements
Module: rtc_ad_bus

Interface
REQ-001 SHALL have parameter T_PHASE, default 4, giving the length of every bus phase in clk cycles (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port req, input, 1, request strobe from the chronometer/clock FSMs, sampled only while busy=0.
REQ-005 SHALL have port wr, input, 1, transfer type (1 = write, 0 = read), sampled with req.
REQ-006 SHALL have port address, input, 8, RTC register address, sampled with req.
REQ-007 SHALL have port data_mod, input, 8, write data, sampled with req.
REQ-008 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port data_rd, output, 8, last byte read from the RTC.
REQ-011 SHALL have port ad_out, output, 8, value driven on the multiplexed AD bus.
REQ-012 SHALL have port ad_oe, output, 1, AD bus drive enable; the top-level tristate drives the bus only while this is 1.
REQ-013 SHALL have port ad_in, input, 8, sampled value of the AD bus.
REQ-014 SHALL have ports CS_n, RD_n, WR_n, output, 1 each, active-low chip select, read strobe and write strobe to the RTC.
REQ-015 SHALL have port AD_n, output, 1, address/data select (0 = address phase, 1 = data phase).

Function
REQ-016 SHALL implement FSM states IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD.
REQ-017 SHALL leave IDLE only on req=1 with busy=0, latching wr, address and data_mod into internal registers and entering A_SETUP on the next edge.
REQ-018 SHALL keep each non-IDLE state for exactly T_PHASE cycles, then advance in the listed order; D_HOLD returns to IDLE.
REQ-019 SHALL assert busy=1 in every non-IDLE state and busy=0 in IDLE.
REQ-020 SHALL, in A_SETUP/A_STROBE/A_HOLD, drive AD_n=0, ad_oe=1, ad_out=latched address.
REQ-021 SHALL, in A_STROBE only, drive CS_n=0 and WR_n=0.
REQ-022 SHALL, in D_SETUP/D_STROBE/D_HOLD, drive AD_n=1.
REQ-023 SHALL, for writes in data states, drive ad_oe=1 and ad_out=latched data, with CS_n=0 and WR_n=0 in D_STROBE only.
REQ-024 SHALL, for reads in data states, drive ad_oe=0, with CS_n=0 and RD_n=0 in D_STROBE only.
REQ-025 SHALL, for reads, capture ad_in into data_rd on the last cycle of D_STROBE.
REQ-026 SHALL otherwise hold data_rd; writes never modify it.
REQ-027 SHALL pulse done=1 for exactly one cycle, the first IDLE cycle after D_HOLD; transfer latency is 6*T_PHASE+1 cycles from the req edge to done.
REQ-028 SHALL accept a new req in the same cycle done is high, giving back-to-back transfers.
REQ-029 SHALL ignore req while busy=1, with no queuing and no effect on the transfer in progress.
REQ-030 SHALL, in IDLE, drive CS_n=RD_n=WR_n=1, AD_n=1, ad_oe=0, ad_out=0.
REQ-031 SHALL never assert RD_n=0 and WR_n=0 simultaneously, and never assert ad_oe=1 while RD_n=0.
REQ-032 SHALL use a phase counter ceil(log2(T_PHASE)) bits wide that reloads to 0 on every state change; it SHALL never wrap mid-phase.

Reset
REQ-033 SHALL, while Reset=0, asynchronously force state=IDLE, counter=0, busy=0, done=0, data_rd=0x00, ad_out=0x00, ad_oe=0, and CS_n=RD_n=WR_n=AD_n=1.
REQ-034 SHALL abort any transfer on reset mid-operation, with strobes released in the same cycle and no done pulse.
REQ-035 SHALL, after Reset rises, accept req no earlier than the first full clk cycle.

Structure
REQ-036 SHALL take the state encoding, the T_PHASE default and the strobe idle levels from shared package rtc_bus_pkg.
REQ-037 SHALL instantiate one sub-module, phase_timer, containing the parameterised phase counter with a terminal-count output.

Verification
REQ-038 SHALL cover a write with T_PHASE=4, req with wr=1, address=0x21, data_mod=0x45:
- address phase: ad_out=0x21 with AD_n=0 for 12 cycles, WR_n=0 and CS_n=0 for 4 of them;
- data phase: ad_out=0x45 with WR_n=0 for 4 cycles;
- done at cycle 25.
REQ-039 SHALL cover a read of address 0x22 with ad_in=0x59 in D_STROBE: ad_oe=0 through the data phase, RD_n=0 for 4 cycles, data_rd=0x59 at done, data_rd unchanged by a following write.
REQ-040 SHALL cover back-to-back traffic: req held high through two transfers gives two done pulses 25 cycles apart; req pulses while busy=1 produce no extra transfer.
REQ-041 SHALL cover reset mid-transfer: Reset=0 during D_STROBE gives all strobes 1, ad_oe=0, busy=0 immediately, no done, and data_rd=0x00.
REQ-042 SHALL cover, at T_PHASE=2 and T_PHASE=255, phase lengths exactly equal to T_PHASE, with an assertion checking REQ-031 on every cycle.
